// File: rtl/grid_sprite_renderer.sv
// grid_sprite_renderer: per-frame shadowed tile grid mapped to sprite ROM texels, LAT = ROM_LAT+2 pipeline.
// Define GRID_LINES_EN to overlay 12'h888 lines on the first row/column of every tile.
module grid_sprite_renderer #(
    parameter int TILE_LOG2 = 5,
    parameter int GRID_COLS = 8,
    parameter int GRID_ROWS = 13,
    parameter int ORIGIN_X = 112,
    parameter int ORIGIN_Y = 112,
    parameter int CODE_W = 4,
    parameter int NUM_SPRITES = 11,
    parameter int ROM_LAT = 2,
    parameter logic [11:0] BG_COLOR = 12'h000,
    parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic [GRID_COLS*GRID_ROWS*CODE_W-1:0]        object_grid,
    input  logic [10:0]                                  hcount,
    input  logic [9:0]                                   vcount,
    input  logic                                         hsync,
    input  logic                                         vsync,
    input  logic                                         blank,
    output logic [$clog2(NUM_SPRITES)+2*TILE_LOG2-1:0]   rom_addr,
    input  logic [11:0]                                  rom_data,
    output logic                                         hsync_out,
    output logic                                         vsync_out,
    output logic                                         blank_out,
    output logic [11:0]                                  pixel_out,
    output logic                                         in_grid_out
);
    localparam int LAT = ROM_LAT + 2;
    localparam int SW = $clog2(NUM_SPRITES);
    localparam int CBW = GRID_COLS > 1 ? $clog2(GRID_COLS) : 1;
    localparam int RBW = GRID_ROWS > 1 ? $clog2(GRID_ROWS) : 1;
    localparam logic [10:0] X0 = 11'(ORIGIN_X);
    localparam logic [11:0] X1 = 12'(ORIGIN_X + (GRID_COLS << TILE_LOG2));
    localparam logic [9:0] Y0 = 10'(ORIGIN_Y);
    localparam logic [10:0] Y1 = 11'(ORIGIN_Y + (GRID_ROWS << TILE_LOG2));
    localparam logic [CODE_W:0] NS = (CODE_W + 1)'(NUM_SPRITES);
    localparam logic [3:0] SB_IDLE = 4'b0111;

    logic [GRID_COLS*GRID_ROWS*CODE_W-1:0] r_shadow;
    logic r_vs_prev;
    logic [$clog2(NUM_SPRITES)+2*TILE_LOG2-1:0] r_rom_addr;
    logic [3:0] r_sb [LAT-1];
    logic [11:0] r_pixel;
    logic r_hs, r_vs, r_blank, r_ig;

    logic [CODE_W-1:0] w_cells [1<<CBW][1<<RBW];
    genvar c, r;
    generate
        for (c = 0; c < (1 << CBW); c++) begin : g_col
            for (r = 0; r < (1 << RBW); r++) begin : g_row
                if (c < GRID_COLS && r < GRID_ROWS) begin : g_cell
                    assign w_cells[c][r] = r_shadow[(c*GRID_ROWS+r)*CODE_W +: CODE_W];
                end else begin : g_pad
                    assign w_cells[c][r] = '0;
                end
            end
        end
    endgenerate

    // Underflow left of/above the origin wraps dx/dy; in_grid masks it.
    logic [10:0] w_dx;
    logic [9:0] w_dy;
    logic w_in_grid;
    logic [CBW-1:0] w_col;
    logic [RBW-1:0] w_row;
    logic [CODE_W-1:0] w_raw;
    logic [SW-1:0] w_code;
    logic [3:0] w_sb_in, w_last;
    logic w_show;
    logic [11:0] w_pixel;
    logic w_ig;

    assign w_dx = hcount - X0;
    assign w_dy = vcount - Y0;
    assign w_in_grid = hcount >= X0 && {1'b0, hcount} < X1 && vcount >= Y0 && {1'b0, vcount} < Y1;
    assign w_col = CBW'(w_dx >> TILE_LOG2);
    assign w_row = RBW'(w_dy >> TILE_LOG2);
    assign w_raw = w_cells[w_col][w_row];
    assign w_code = (w_in_grid && {1'b0, w_raw} < NS) ? w_raw[SW-1:0] : '0;
    assign w_sb_in = {w_code != '0, hsync, vsync, blank};
    assign w_last = r_sb[LAT-2];
    assign w_show = w_last[3] && rom_data != TRANSPARENT;

`ifdef GRID_LINES_EN
    logic [LAT-2:0] r_line;
    logic w_line;
    assign w_line = w_in_grid && (w_dx[TILE_LOG2-1:0] == '0 || w_dy[TILE_LOG2-1:0] == '0);
    assign w_pixel = w_last[0] ? 12'h000 : r_line[LAT-2] ? 12'h888 : w_show ? rom_data : BG_COLOR;
    assign w_ig = !w_last[0] && (r_line[LAT-2] || w_show);
    always_ff @(posedge clock) begin
        if (reset) r_line <= '0;
        else r_line <= {r_line[LAT-3:0], w_line};
    end
`else
    assign w_pixel = w_last[0] ? 12'h000 : w_show ? rom_data : BG_COLOR;
    assign w_ig = !w_last[0] && w_show;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_shadow <= '0;
            r_vs_prev <= 1'b1;
            r_rom_addr <= '0;
            for (int i = 0; i < LAT - 1; i++) r_sb[i] <= SB_IDLE;
            r_pixel <= 12'h000;
            r_hs <= 1'b1;
            r_vs <= 1'b1;
            r_blank <= 1'b1;
            r_ig <= 1'b0;
        end else begin
            if (r_vs_prev && !vsync) r_shadow <= object_grid;
            r_vs_prev <= vsync;
            r_rom_addr <= {w_code, w_dy[TILE_LOG2-1:0], w_dx[TILE_LOG2-1:0]};
            r_sb[0] <= w_sb_in;
            for (int i = 1; i < LAT - 1; i++) r_sb[i] <= r_sb[i-1];
            r_pixel <= w_pixel;
            r_hs <= w_last[2];
            r_vs <= w_last[1];
            r_blank <= w_last[0];
            r_ig <= w_ig;
        end
    end

    assign rom_addr = r_rom_addr;
    assign pixel_out = r_pixel;
    assign hsync_out = r_hs;
    assign vsync_out = r_vs;
    assign blank_out = r_blank;
    assign in_grid_out = r_ig;
endmodule

// File: tb/tb_grid_sprite_renderer.sv
// tb_grid_sprite_renderer: random and directed raster scans checked against a behavioural frame model.
module tb_grid_sprite_renderer;
    localparam int LAT = 4;
    localparam int ROM_LAT = 2;
    localparam logic [16:0] IDLE = {12'h000, 1'b0, 1'b1, 1'b1, 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [415:0] object_grid = '0;
    logic [10:0] hcount = '0;
    logic [9:0] vcount = '0;
    logic hsync = 1'b1, vsync = 1'b1, blank = 1'b1;
    logic [13:0] rom_addr;
    logic [11:0] rom_data;
    logic hsync_out, vsync_out, blank_out, in_grid_out;
    logic [11:0] pixel_out;

    grid_sprite_renderer dut (
        .clock(clk), .reset(rst), .object_grid(object_grid), .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .blank(blank), .rom_addr(rom_addr), .rom_data(rom_data),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out),
        .pixel_out(pixel_out), .in_grid_out(in_grid_out)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] texel(input logic [13:0] a);
        logic [3:0] cd = a[13:10];
        logic [4:0] ty = a[9:5];
        logic [4:0] tx = a[4:0];
        if (cd == 4'd1) return (tx == 5'd5 && ty == 5'd5) ? 12'hF0F : 12'h0A0;
        if (tx == ty) return 12'hF0F;
        return {cd, ty[3:0], tx[3:0]};
    endfunction

    logic [11:0] rq [ROM_LAT];
    always @(posedge clk) begin
        rq[0] <= texel(rom_addr);
        for (int i = 1; i < ROM_LAT; i++) rq[i] <= rq[i-1];
    end
    assign rom_data = rq[ROM_LAT-1];

    logic [415:0] mgrid = '0;
    logic m_vs_prev = 1'b1;
    logic [16:0] q [$];
    logic was_reset = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    function automatic logic [16:0] model(input int h, input int v, input logic hs, input logic vs, input logic bl);
        int dx = h - 112;
        int dy = v - 112;
        logic [11:0] pix = 12'h000;
        logic ig = 1'b0;
        if (!bl) begin
            pix = 12'h000;
            if (dx >= 0 && dx < 256 && dy >= 0 && dy < 416) begin
                int c = dx / 32;
                int r = dy / 32;
                int tx = dx % 32;
                int ty = dy % 32;
                logic [3:0] code = mgrid[(c*13+r)*4 +: 4];
                if (code != 0 && code < 11) begin
                    logic [11:0] t = texel({code, 5'(ty), 5'(tx)});
                    if (t != 12'hF0F) begin
                        pix = t;
                        ig = 1'b1;
                    end
                end
`ifdef GRID_LINES_EN
                if (tx == 0 || ty == 0) begin
                    pix = 12'h888;
                    ig = 1'b1;
                end
`endif
            end
        end
        return {pix, ig, hs, vs, bl};
    endfunction

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] e);
        n_checks++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic step(input int h, input int v, input logic hs, input logic vs, input logic bl, input logic rs);
        @(negedge clk);
        if (q.size() == LAT) check("pixel", {pixel_out, in_grid_out, hsync_out, vsync_out, blank_out}, q.pop_front());
        if (was_reset) check("rom_addr_reset", {3'b0, rom_addr}, 17'h0);
        was_reset = rs;
        rst = rs;
        hcount = 11'(h);
        vcount = 10'(v);
        hsync = hs;
        vsync = vs;
        blank = bl;
        if (rs) begin
            q.delete();
            repeat (LAT) q.push_back(IDLE);
            mgrid = '0;
            m_vs_prev = 1'b1;
        end else begin
            q.push_back(model(h, v, hs, vs, bl));
            if (m_vs_prev && !vs) mgrid = object_grid;
            m_vs_prev = vs;
        end
    endtask

    task automatic vsync_fall();
        step(0, 0, 1, 1, 1, 0);
        step(0, 0, 1, 1, 1, 0);
        step(0, 0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 1, 0);
    endtask

    task automatic line(input int v, input int h0, input int h1, input logic rnd);
        for (int h = h0; h <= h1; h++)
            step(h, v, rnd ? 1'($urandom) : 1'b1, 1'b1, rnd ? ($urandom % 8 == 0) : 1'b0, 0);
    endtask

    task automatic rand_grid();
        for (int i = 0; i < 104; i++)
            object_grid[i*4 +: 4] = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom_range(1, 13));
        object_grid[3:0] = 4'd13;
    endtask

    initial begin
        repeat (3) step(0, 0, 1, 1, 1, 1);
        repeat (6) step(0, 0, 1, 1, 1, 0);
        vsync_fall();
        foreach (q[i]) ;
        line(100, 100, 380, 0);
        line(120, 100, 380, 1);
        line(527, 100, 380, 0);
        object_grid[(2*13+3)*4 +: 4] = 4'd1;
        vsync_fall();
        line(207, 170, 215, 0);
        line(208, 170, 215, 0);
        line(213, 170, 215, 0);
        line(239, 170, 215, 0);
        line(240, 170, 215, 0);
        rand_grid();
        vsync_fall();
        for (int k = 0; k < 12; k++) line($urandom_range(100, 540), 100, 380, 1);
        line(112, 100, 380, 1);
        rand_grid();
        for (int k = 0; k < 4; k++) line($urandom_range(110, 530), 100, 380, 1);
        vsync_fall();
        for (int k = 0; k < 4; k++) line($urandom_range(110, 530), 100, 380, 1);
        line(130, 100, 200, 0);
        step(201, 130, 1, 1, 0, 1);
        line(130, 202, 380, 0);
        line(150, 100, 380, 1);
        vsync_fall();
        line(150, 100, 380, 1);
        line(300, 100, 380, 1);
        repeat (LAT + 1) step(0, 0, 1, 1, 1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
